// File: rtl/ahb_replay_fifo_if.sv
// Bundles the write/read/replay control and status signals of ahb_replay_fifo.
// The master drives requests; the slave (the FIFO) returns data and status.
interface ahb_replay_fifo_if #(
  parameter int DATA_W = 67,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              rewind;
  logic [ADDR_W:0]   rewind_len;
  logic              rel;          // free every entry read so far
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   avail;
  logic [ADDR_W:0]   used;
  logic              ovf_err;
  logic              rew_err;

  modport master (
    output wr_en, wr_data, rd_en, rewind, rewind_len, rel,
    input  rd_data, rd_valid, empty, full, almost_full, avail, used, ovf_err, rew_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, rewind, rewind_len, rel,
    output rd_data, rd_valid, empty, full, almost_full, avail, used, ovf_err, rew_err
  );
endinterface

// File: rtl/ahb_replay_fifo.sv
// Replay FIFO: read entries stay resident until released, so the reader can
// rewind and re-fetch them. Three wrap-bit pointers: write, read, release.
module ahb_replay_fifo #(
  parameter int DATA_W    = 67,
  parameter int ADDR_W    = 4,
  parameter int AFULL_THR = (1 << ADDR_W) - 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_replay_fifo_if.slave  bus
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_P = (ADDR_W+1)'(AFULL_THR);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wp_reg, rp_reg, cp_reg;
  logic [ADDR_W:0]   wp_next, rp_next, cp_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg, ovf_err_reg, rew_err_reg;

  logic [ADDR_W:0]   avail, used, unrel;
  logic              empty, full, wr_acc, rd_acc, rew_clamp;

  assign avail     = wp_reg - rp_reg;
  assign used      = wp_reg - cp_reg;
  assign unrel     = rp_reg - cp_reg;
  assign empty     = (avail == '0);
  assign full      = (used == DEPTH_P);
  assign wr_acc    = bus.wr_en & ~full;
  assign rd_acc    = bus.rd_en & ~empty & ~bus.rewind;
  assign rew_clamp = (bus.rewind_len > unrel);

  always_comb begin
    wp_next = wr_acc ? wp_reg + 1'b1 : wp_reg;
    rp_next = rp_reg;
    if (bus.rewind) begin
      rp_next = rew_clamp ? cp_reg : rp_reg - bus.rewind_len;
    end else if (rd_acc) begin
      rp_next = rp_reg + 1'b1;
    end
    // Release follows this cycle's read/rewind; full was already sampled for the write.
    cp_next = bus.rel ? rp_next : cp_reg;
  end

  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      mem[wp_reg[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      cp_reg       <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      ovf_err_reg  <= 1'b0;
      rew_err_reg  <= 1'b0;
    end else begin
      wp_reg       <= wp_next;
      rp_reg       <= rp_next;
      cp_reg       <= cp_next;
      if (rd_acc) begin
        rd_data_reg <= mem[rp_reg[ADDR_W-1:0]];
      end
      rd_valid_reg <= rd_acc;
      ovf_err_reg  <= bus.wr_en & full;
      rew_err_reg  <= bus.rewind & rew_clamp;
    end
  end

  assign bus.rd_data     = rd_data_reg;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (used >= AFULL_P);
  assign bus.avail       = avail;
  assign bus.used        = used;
  assign bus.ovf_err     = ovf_err_reg;
  assign bus.rew_err     = rew_err_reg;

endmodule

// File: tb/tb_ahb_replay_fifo.sv
// Directed plus random checks of ahb_replay_fifo against a queue-based model:
// the queue holds every resident entry, rd_idx marks how many have been read.
module tb_ahb_replay_fifo;

  localparam int DW = 67;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;

  logic HCLK;
  logic HRESETn;

  ahb_replay_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ahb_replay_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  logic [DW-1:0] q [$];
  int            rd_idx;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rd_idx    = 0;
    last_data = '0;
  endtask

  task automatic check_all(input bit ev, input bit eovf, input bit erew);
    int sz;
    sz = q.size();
    chk("rd_valid",    128'(bus.rd_valid),    128'(ev));
    chk("rd_data",     128'(bus.rd_data),     128'(last_data));
    chk("ovf_err",     128'(bus.ovf_err),     128'(eovf));
    chk("rew_err",     128'(bus.rew_err),     128'(erew));
    chk("avail",       128'(bus.avail),       128'(sz - rd_idx));
    chk("used",        128'(bus.used),        128'(sz));
    chk("empty",       128'(bus.empty),       128'(sz == rd_idx));
    chk("full",        128'(bus.full),        128'(sz == DEPTH));
    chk("almost_full", 128'(bus.almost_full), 128'(sz >= AFULL));
  endtask

  task automatic drive_idle();
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rewind     = 1'b0;
    bus.rewind_len = '0;
    bus.rel        = 1'b0;
  endtask

  // One clock of stimulus; model update follows the FIFO rules directly.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit rw, input int len, input bit rl);
    bit full_pre, ev, eovf, erew;
    full_pre = (q.size() == DEPTH);
    bus.wr_en      = w;
    bus.wr_data    = d;
    bus.rd_en      = r;
    bus.rewind     = rw;
    bus.rewind_len = 5'(len);
    bus.rel        = rl;
    ev   = 1'b0;
    erew = 1'b0;
    eovf = w && full_pre;
    if (rw) begin
      if (len > rd_idx) begin
        erew   = 1'b1;
        rd_idx = 0;
      end else begin
        rd_idx = rd_idx - len;
      end
    end else if (r && rd_idx < q.size()) begin
      last_data = q[rd_idx];
      rd_idx++;
      ev = 1'b1;
    end
    if (w && !full_pre) q.push_back(d);
    if (rl) begin
      repeat (rd_idx) void'(q.pop_front());
      rd_idx = 0;
    end
    @(posedge HCLK);
    #1;
    txn++;
    $display("[TB] txn %0d wr=%0b rd=%0b rew=%0b len=%0d rel=%0b used=%0d avail=%0d rd_valid=%0b",
             txn, w, r, rw, len, rl, q.size(), q.size() - rd_idx, ev);
    check_all(ev, eovf, erew);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    drive_idle();
    model_reset();
    HRESETn = 1'b0;
    #3;
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Fill to full, then one overflowing write.
    for (int i = 1; i <= 16; i++) step(1, DW'(i), 0, 0, 0, 0);
    step(1, DW'(17), 0, 0, 0, 0);

    // Drain without release: full stays until the release.
    for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);

    // Rewind by 2 replays the last two entries.
    step(1, DW'('hA), 0, 0, 0, 0);
    step(1, DW'('hB), 0, 0, 0, 0);
    step(1, DW'('hC), 0, 0, 0, 0);
    step(1, DW'('hD), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 1, 2, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);

    // Over-long rewind clamps to the release point.
    for (int i = 0; i < 3; i++) step(1, rnd_data(), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 1, 5, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 1, 0, 0);

    // Read blocked by same-cycle rewind.
    step(0, '0, 1, 1, 1, 0);
    step(0, '0, 0, 0, 0, 1);

    // Write at full with same-cycle release is dropped, retry lands.
    for (int i = 0; i < 16; i++) step(1, rnd_data(), 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(1, rnd_data(), 0, 0, 0, 1);
    step(1, rnd_data(), 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 1);

    // Asynchronous reset mid-cycle with seven entries resident.
    while (q.size() < 7) step(1, rnd_data(), 0, 0, 0, 0);
    while (q.size() > 7) step(0, '0, 1, 0, 0, 1);
    chk("used_before_reset", 128'(bus.used), 128'(7));
    drive_idle();
    #3;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check_all(1'b0, 1'b0, 1'b0);
    #3;
    HRESETn = 1'b1;
    step(1, DW'('h5A), 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    chk("post_reset_data", 128'(bus.rd_data), 128'('h5A));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 55, rnd_data(),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 6,
           int'($urandom_range(0, 20)),
           $urandom_range(0, 99) < 12);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_replay_fifo.md
AHB_REPLAY_FIFO -- requirements
Module: ahb_replay_fifo

Interface
REQ-001 Parameter DATA_W, default 67, width of every stored entry.
REQ-002 Parameter ADDR_W, default 4, giving DEPTH = 2^ADDR_W entries.
REQ-003 Parameter AFULL_THR, default DEPTH-2, occupancy at which almost_full asserts; legal range 1..DEPTH.
REQ-004 HCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 HRESETn  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 rd_en  input  1  read request.
REQ-009 rewind  input  1  move read pointer back by rewind_len (replay).
REQ-010 rewind_len  input  ADDR_W+1  number of entries to replay.
REQ-011 release  input  1  free all entries read so far.
REQ-012 rd_data  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  rd_data holds a newly read entry this cycle.
REQ-014 empty  output  1  no unread entries.
REQ-015 full  output  1  no free slots (unread plus read-but-unreleased).
REQ-016 almost_full  output  1  occupancy >= AFULL_THR.
REQ-017 avail  output  ADDR_W+1  unread entry count.
REQ-018 used  output  ADDR_W+1  occupied entry count (unread plus unreleased).
REQ-019 ovf_err  output  1  one-cycle pulse: write dropped because full.
REQ-020 rew_err  output  1  one-cycle pulse: rewind_len exceeded unreleased entries and was clamped.

Function
REQ-021 Three ADDR_W+1-bit pointers SHALL be kept: wp (write), rp (read), cp (release); the MSB is a wrap bit; all arithmetic is modulo 2^(ADDR_W+1).
REQ-022 avail SHALL equal wp-rp, used SHALL equal wp-cp; both are combinational from the registered pointers.
REQ-023 empty SHALL be (avail==0); full SHALL be (used==DEPTH); almost_full SHALL be (used>=AFULL_THR).
REQ-024 A write SHALL be accepted when wr_en=1 and full=0: mem[wp[ADDR_W-1:0]] <= wr_data, wp <= wp+1.
REQ-025 wr_en=1 with full=1 SHALL leave memory and wp unchanged and pulse ovf_err for one cycle.
REQ-026 A read SHALL be accepted when rd_en=1, empty=0 and rewind=0: rd_data <= mem[rp[ADDR_W-1:0]], rp <= rp+1, rd_valid=1 the next cycle (latency 1).
REQ-027 rd_en with empty=1 or with rewind=1 SHALL be ignored; rd_valid=0 next cycle; rd_data holds its previous value.
REQ-028 A read SHALL NOT free a slot; only release frees slots, so a read never clears full.
REQ-029 rewind=1 SHALL set rp <= rp - min(rewind_len, rp-cp); if rewind_len > rp-cp, rp <= cp and rew_err pulses one cycle.
REQ-030 release=1 SHALL set cp <= rp_next, where rp_next is rp after any same-cycle read or rewind.
REQ-031 A same-cycle write SHALL be evaluated against full before that cycle's release; freed slots become writable the following cycle.
REQ-032 Simultaneous accepted write and read SHALL both take effect; avail unchanged, used +1.
REQ-033 rewind_len=0 with rewind=1 SHALL leave rp unchanged, block the read, and not pulse rew_err.
REQ-034 Replayed entries SHALL return the identical data originally written, in the original order.
REQ-035 Memory SHALL be plain storage with no reset; only pointers and output registers are reset.

Reset
REQ-036 While HRESETn=0, independent of HCLK: wp=rp=cp=0, rd_data=0, rd_valid=0, ovf_err=0, rew_err=0; hence empty=1, full=0, almost_full=0, avail=0, used=0.
REQ-037 Reset asserted mid-operation SHALL discard all contents; first operation after deassertion behaves as from empty.

Verification
REQ-038 Reset, write 0x1..0x10 (16 writes, DEPTH=16) -> full=1, used=16, almost_full from the 14th write; 17th write -> ovf_err pulse, used stays 16.
REQ-039 From full, read 16 without release -> empty=1, full=1 still; pulse release -> used=0, full=0 next cycle.
REQ-040 Write A,B,C,D; read all four; rewind with rewind_len=2 -> avail=2; reads return C then D with rd_valid each following cycle.
REQ-041 After 3 reads with cp=0, rewind_len=5 -> rp=cp, avail=3, rew_err pulse one cycle; replay returns the first 3 entries.
REQ-042 rd_en and rewind in same cycle -> no rd_valid next cycle, rp moved by rewind only; wr_en at full with same-cycle release -> write dropped, accepted on retry next cycle.
REQ-043 Assert HRESETn=0 between clock edges with used=7 -> all outputs at reset values immediately; after release of reset empty=1, write/read of 0x5A returns 0x5A.
